// File: rtl/tdpram_port_arbiter_if.sv
// Requester-side bus of the TDPRAM port-A arbiter: packed per-requester
// valid/ready request lanes plus the shared read-response return path.
interface tdpram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;

  // Requesters drive requests and observe grants/responses.
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  // The arbiter consumes requests and returns grants/responses.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/tdpram_port_arbiter.sv
// Round-robin arbiter sharing port A of a single-clock true dual-port RAM
// between NUM_REQ valid/ready requesters. After every reset the whole RAM is
// swept to zero before any request is granted. Read data is routed back to
// the requester that issued the read, one cycle after acceptance.
//
// Optional build macro: TDPRAM_ARB_RESP_REG_EN adds one register stage on
// resp_valid/resp_data (read latency 2, throughput unchanged).
module tdpram_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 2048,
  parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
  input  logic                  clock,
  input  logic                  reset,
  tdpram_port_arbiter_if.slave  bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  localparam int                    PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]        NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic {
    INIT_S = 1'b0,
    ARB_S  = 1'b1
  } state_e;

  state_e                  state_q,    state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]        rr_ptr_q,   rr_ptr_d;
  logic                    rd_pend_q,  rd_pend_d;
  // One-hot copy of the grant that issued the outstanding read.
  logic [NUM_REQ-1:0]      rd_owner_q, rd_owner_d;
  // Last address presented to the RAM, held while nobody is granted.
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  // Last returned read word, held between responses.
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]      resp_valid_d;

  logic [NUM_REQ-1:0]      rr_grant;
  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W:0]          cand;
  logic                    found;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (cand == (PTR_W + 1)'(i)) && bus.req_valid[i]) begin
          rr_grant[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  // Next-state and RAM port-A drive: zero sweep in INIT, winner's slice in ARB.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    grant      = '0;
    ram_we     = 1'b0;
    ram_addr   = ram_addr_q;
    ram_din    = '0;

    case (state_q)
      INIT_S: begin
        // Write enable follows reset so the RAM is never written while held in reset.
        ram_we     = reset;
        ram_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ARB_S;
        end
      end
      ARB_S: begin
        grant = rr_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rr_grant[i]) begin
            ram_addr   = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din    = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            ram_we     = bus.req_write[i];
            rd_pend_d  = ~bus.req_write[i];
            rd_owner_d = rr_grant;
            rr_ptr_d   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
          end
        end
      end
      default: begin
        state_d = INIT_S;
      end
    endcase

    ram_addr_d = ram_addr;
  end

  // Read response: RAM output is valid the cycle after the read was accepted.
  always_comb begin
    resp_valid_d = rd_pend_q ? rd_owner_q : '0;
    resp_data_d  = rd_pend_q ? ram_dout : resp_data_q;
  end

  // State, sweep counter, pointer, pending read and held address/data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT_S;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= '0;
      ram_addr_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      ram_addr_q  <= ram_addr_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready = grant;
  assign init_done     = (state_q == ARB_S);

`ifdef TDPRAM_ARB_RESP_REG_EN
  logic [NUM_REQ-1:0]    resp_valid_out_q;
  logic [DATA_WIDTH-1:0] resp_data_out_q;

  // Extra retiming stage on the response path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_out_q <= '0;
      resp_data_out_q  <= '0;
    end else begin
      resp_valid_out_q <= resp_valid_d;
      resp_data_out_q  <= resp_data_d;
    end
  end

  assign bus.resp_valid = resp_valid_out_q;
  assign bus.resp_data  = resp_data_out_q;
`else
  assign bus.resp_valid = resp_valid_d;
  assign bus.resp_data  = resp_data_d;
`endif

endmodule
